// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives load/store requests to a variable-latency data memory
// over req/ack, holding the upstream pipeline until the access completes or times out.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [31:0] ALUresult,
  input  logic [31:0] writeData,
  input  logic [4:0]  writeReg,
  output logic        stall,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic [31:0] ALUresultOut,
  output logic [31:0] readDataOut,
  output logic [4:0]  writeRegOut,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             reg_write_q, reg_write_d;
  logic             memto_reg_q, memto_reg_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             abort_q, abort_d;
  logic             misalign_q, misalign_d;
  logic             timeout_q, timeout_d;

  logic memop, misaligned;
  assign memop      = in_valid & (MemRead | MemWrite);
  assign misaligned = |ALUresult[1:0];

  assign mem_addr     = alu_q;
  assign mem_wdata    = wdata_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    memto_reg_d = memto_reg_q;
    alu_d       = alu_q;
    wdata_d     = wdata_q;
    wreg_d      = wreg_q;
    rdata_d     = rdata_q;
    abort_d     = abort_q;
    misalign_d  = misalign_q;
    timeout_d   = timeout_q;

    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    RegWriteOut  = 1'b0;
    MemtoRegOut  = memto_reg_q;
    ALUresultOut = alu_q;
    readDataOut  = rdata_q;
    writeRegOut  = wreg_q;

    case (state_q)
      IDLE: begin
        // Pass-through path: no added latency for non-memory instructions
        RegWriteOut  = RegWrite & in_valid & ~memop;
        MemtoRegOut  = MemtoReg;
        ALUresultOut = ALUresult;
        readDataOut  = '0;
        writeRegOut  = writeReg;
        if (memop) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            stall       = 1'b1;
            mem_read_d  = MemRead;
            mem_write_d = MemWrite;
            reg_write_d = RegWrite;
            memto_reg_d = MemtoReg;
            alu_d       = ALUresult;
            wdata_d     = writeData;
            wreg_d      = writeReg;
            rdata_d     = '0;
            abort_d     = 1'b0;
            cnt_d       = '0;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = mem_write_q & ~mem_read_q;
        // Ack takes priority over a timeout landing on the same edge
        if (mem_ack) begin
          if (mem_read_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        RegWriteOut = reg_write_q & ~abort_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      alu_q       <= '0;
      wdata_q     <= '0;
      wreg_q      <= '0;
      rdata_q     <= '0;
      abort_q     <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      wreg_q      <= wreg_d;
      rdata_q     <= rdata_d;
      abort_q     <= abort_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: per-instruction cycle schedule derived from the
// access rules, compared every cycle, plus literal checks on the worked examples.
module tb_mem_access_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, MemRead, MemWrite, RegWrite, MemtoReg;
  logic [31:0] ALUresult, writeData;
  logic [4:0]  writeReg;
  logic        stall, RegWriteOut, MemtoRegOut;
  logic [31:0] ALUresultOut, readDataOut;
  logic [4:0]  writeRegOut;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, misalign_err, timeout_err;

  mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUresult(ALUresult), .writeData(writeData),
    .writeReg(writeReg), .stall(stall), .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut),
    .ALUresultOut(ALUresultOut), .readDataOut(readDataOut), .writeRegOut(writeRegOut),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .misalign_err(misalign_err),
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, rwo, m2r, req, we, mis, to, chk_data;
    logic [31:0] alu, rdata, addr, wdata;
    logic [4:0]  wreg;
  } exp_t;

  exp_t e;
  bit   exp_vld = 0;
  bit   mis_m = 0, to_m = 0;
  int   nvec = 0, nfail = 0;
  int   stall_run = 0, last_stall_run = 0;
  logic [31:0] last_rdata;
  logic        last_rwo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_vld) begin
      chk("stall", 32'(stall), 32'(e.stall));
      chk("RegWriteOut", 32'(RegWriteOut), 32'(e.rwo));
      chk("mem_req", 32'(mem_req), 32'(e.req));
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
      chk("timeout_err", 32'(timeout_err), 32'(e.to));
      if (e.chk_data) begin
        chk("MemtoRegOut", 32'(MemtoRegOut), 32'(e.m2r));
        chk("ALUresultOut", ALUresultOut, e.alu);
        chk("readDataOut", readDataOut, e.rdata);
        chk("writeRegOut", 32'(writeRegOut), 32'(e.wreg));
      end
      if (e.req) begin
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
      end
      if (stall) stall_run++;
      else begin
        last_stall_run = stall_run;
        stall_run      = 0;
        last_rdata     = readDataOut;
        last_rwo       = RegWriteOut;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    in_valid  = 1'($urandom);
    MemRead   = 1'($urandom);
    MemWrite  = 1'($urandom);
    RegWrite  = 1'($urandom);
    MemtoReg  = 1'($urandom);
    ALUresult = $urandom;
    writeData = $urandom;
    writeReg  = 5'($urandom);
  endtask

  function automatic exp_t blank();
    exp_t r;
    r = '{default: '0};
    r.mis = mis_m;
    r.to  = to_m;
    return r;
  endfunction

  // d = BUSY cycle on which memory acks (1-based); 0 or >T means it never does
  task automatic run_instr(input bit v, mr, mw, rw, m2r, input logic [31:0] alu, wd,
                           input logic [4:0] wr, input int d, input logic [31:0] rd);
    bit memop, mis, acked;
    int n;
    memop = v & (mr | mw);
    mis   = alu[1:0] != 2'b00;
    step();
    in_valid = v; MemRead = mr; MemWrite = mw; RegWrite = rw; MemtoReg = m2r;
    ALUresult = alu; writeData = wd; writeReg = wr;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    e = blank();
    if (!memop) begin
      e.chk_data = 1; e.rwo = rw & v; e.m2r = m2r; e.alu = alu; e.rdata = 0; e.wreg = wr;
    end else if (!mis) e.stall = 1;
    exp_vld = 1;
    if (memop && mis) mis_m = 1;
    if (memop && !mis) begin
      acked = (d >= 1) && (d <= T);
      n = acked ? d : T;
      for (int i = 1; i <= n; i++) begin
        step();
        scramble();
        mem_ack   = (i == d);
        mem_rdata = (i == d) ? rd : $urandom;
        e = blank();
        e.stall = 1; e.req = 1; e.we = mw & ~mr; e.addr = alu; e.wdata = wd;
      end
      step();
      scramble();
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      if (!acked) to_m = 1;
      e = blank();
      e.chk_data = 1; e.rwo = rw & acked; e.m2r = m2r; e.alu = alu; e.wreg = wr;
      e.rdata = (acked && mr) ? rd : 32'h0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
    ALUresult = 0; writeData = 0; writeReg = 0; mem_ack = 0; mem_rdata = 0;
    step(); step();
    rst_n = 1;
    settle();
    chk("reset stall", 32'(stall), 0);
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset RegWriteOut", 32'(RegWriteOut), 0);
    chk("reset errs", {misalign_err, timeout_err}, 0);

    // ADD pass-through
    run_instr(1, 0, 0, 1, 0, 32'h10, 0, 5'd3, 0, 0);
    settle();
    chk("add rwo", 32'(RegWriteOut), 1);
    chk("add alu", ALUresultOut, 32'h10);
    chk("add stall", 32'(stall), 0);

    // LW acked on first BUSY cycle
    run_instr(1, 1, 0, 1, 1, 32'h100, 0, 5'd7, 1, 32'hDEADBEEF);
    settle();
    chk("lw stall cycles", last_stall_run, 2);
    chk("lw rdata", last_rdata, 32'hDEADBEEF);
    chk("lw rwo", 32'(last_rwo), 1);

    // SW acked on third BUSY cycle
    run_instr(1, 0, 1, 0, 0, 32'h204, 32'h55, 5'd0, 3, 32'h0);
    settle();
    chk("sw stall cycles", last_stall_run, 4);
    chk("sw rwo", 32'(last_rwo), 0);

    // misaligned LW
    run_instr(1, 1, 0, 1, 1, 32'h102, 0, 5'd4, 1, 0);
    settle();
    chk("mis stall", 32'(stall), 0);
    chk("mis mem_req", 32'(mem_req), 0);
    chk("mis rwo", 32'(RegWriteOut), 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("mis sticky", 32'(misalign_err), 1);

    // LW that never gets acked
    run_instr(1, 1, 0, 1, 1, 32'h300, 0, 5'd9, 0, 0);
    settle();
    chk("to stall cycles", last_stall_run, T + 1);
    chk("to rwo", 32'(last_rwo), 0);
    chk("to flag", 32'(timeout_err), 1);

    // ack racing the final timeout cycle
    run_instr(1, 1, 1, 1, 1, 32'h40, 32'h1, 5'd2, T, 32'hCAFE0001);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      run_instr(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), a, $urandom, 5'($urandom), $urandom_range(6), $urandom);
    end

    // reset while BUSY
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_vld = 0;
    step();
    in_valid = 1; MemRead = 1; MemWrite = 0; ALUresult = 32'h80; mem_ack = 0;
    step(); step();
    settle();
    chk("pre-reset mem_req", 32'(mem_req), 1);
    step();
    rst_n = 0;
    step();
    rst_n = 1; in_valid = 0;
    settle();
    chk("post-reset mem_req", 32'(mem_req), 0);
    chk("post-reset stall", 32'(stall), 0);
    chk("post-reset rwo", 32'(RegWriteOut), 0);
    chk("post-reset errs", {misalign_err, timeout_err}, 0);
    chk("post-reset rdata", readDataOut, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1);
  end
endmodule
